// File: rtl/shared_mult_pkg.sv
// Shared helpers for the time-shared multiplier: channel-index width.
package shared_mult_pkg;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_mult_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
module rr_arbiter
  import shared_mult_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = ch_w(N)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            c;

  // Nothing is granted while held in reset or while the output is stalled.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!found && req[c] && en && !rst_in) begin
        grant[c] = 1'b1;
        idx      = IW'(c);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/shared_mult_rr.sv
// One pipelined multiplier time-shared across N_CH channels with round-robin
// arbitration; products come back tagged with the issuing channel.
module shared_mult_rr
  import shared_mult_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 2,
  parameter int SIGNED      = 0,
  localparam int CH_W = ch_w(N_CH),
  localparam int PW   = 2 * WIDTH
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [N_CH-1:0]            req_valid_in,
  output logic [N_CH-1:0]            req_ready_out,
  input  logic [N_CH-1:0][WIDTH-1:0] a_in,
  input  logic [N_CH-1:0][WIDTH-1:0] b_in,
  output logic                       res_valid_out,
  input  logic                       res_ready_in,
  output logic [PW-1:0]              res_data_out,
  output logic [CH_W-1:0]            res_ch_out
);

  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
    logic [PW-1:0]   product;
  } stage_t;

  stage_t          pipe [PIPE_STAGES];
  stage_t          stage_in;
  logic [N_CH-1:0] grant;
  logic [CH_W-1:0] gnt_idx;
  logic            stall;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [PW-1:0]   a_ext, b_ext;

  assign stall = pipe[PIPE_STAGES-1].valid & ~res_ready_in;

  rr_arbiter #(.N(N_CH)) u_arb (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .en     (~stall),
    .req    (req_valid_in),
    .grant  (grant),
    .idx    (gnt_idx)
  );

  assign req_ready_out = grant;

  // The low 2*WIDTH bits of the extended product are exact in both modes.
  always_comb begin
    a_sel = a_in[gnt_idx];
    b_sel = b_in[gnt_idx];
    if (SIGNED != 0) begin
      a_ext = {{WIDTH{a_sel[WIDTH-1]}}, a_sel};
      b_ext = {{WIDTH{b_sel[WIDTH-1]}}, b_sel};
    end else begin
      a_ext = {{WIDTH{1'b0}}, a_sel};
      b_ext = {{WIDTH{1'b0}}, b_sel};
    end
    stage_in.valid   = |grant;
    stage_in.ch      = gnt_idx;
    stage_in.product = (|grant) ? a_ext * b_ext : '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int s = 0; s < PIPE_STAGES; s++) pipe[s] <= '0;
    end else if (!stall) begin
      pipe[0] <= stage_in;
      for (int s = 1; s < PIPE_STAGES; s++) pipe[s] <= pipe[s-1];
    end
  end

  assign res_valid_out = pipe[PIPE_STAGES-1].valid;
  assign res_data_out  = pipe[PIPE_STAGES-1].product;
  assign res_ch_out    = pipe[PIPE_STAGES-1].ch;

endmodule

// File: tb/tb_shared_mult_rr.sv
// Directed bench for shared_mult_rr: unsigned default build plus a signed build
// sharing the same request inputs.
module tb_shared_mult_rr;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic [3:0]      req_valid_in;
  logic [3:0]      req_ready_out;
  logic [3:0][7:0] a_in, b_in;
  logic            res_valid_out;
  logic            res_ready_in;
  logic [15:0]     res_data_out;
  logic [1:0]      res_ch_out;

  logic [3:0]      s_req_ready;
  logic            s_res_valid;
  logic [15:0]     s_res_data;
  logic [1:0]      s_res_ch;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  shared_mult_rr #(.N_CH(4), .WIDTH(8), .PIPE_STAGES(2), .SIGNED(0)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .a_in          (a_in),
    .b_in          (b_in),
    .res_valid_out (res_valid_out),
    .res_ready_in  (res_ready_in),
    .res_data_out  (res_data_out),
    .res_ch_out    (res_ch_out)
  );

  shared_mult_rr #(.N_CH(4), .WIDTH(8), .PIPE_STAGES(2), .SIGNED(1)) dut_s (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (s_req_ready),
    .a_in          (a_in),
    .b_in          (b_in),
    .res_valid_out (s_res_valid),
    .res_ready_in  (1'b1),
    .res_data_out  (s_res_data),
    .res_ch_out    (s_res_ch)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] d, input logic [1:0] ch);
    chk({tag, "_valid"}, 32'(res_valid_out), 32'(v));
    chk({tag, "_data"},  32'(res_data_out),  32'(d));
    chk({tag, "_ch"},    32'(res_ch_out),    32'(ch));
  endtask

  task automatic step();
    @(negedge clk_in);
  endtask

  initial begin
    rst_in = 1'b1;
    req_valid_in = '0;
    a_in = '0;
    b_in = '0;
    res_ready_in = 1'b1;

    // reset, including requests presented during reset
    step();
    chk_out("rst0", 1'b0, 16'd0, 2'd0);
    chk("rst0_ready", 32'(req_ready_out), 32'h0);
    req_valid_in = 4'hF;
    #1 chk("rst1_ready_req", 32'(req_ready_out), 32'h0);
    step();
    chk_out("rst1", 1'b0, 16'd0, 2'd0);
    rst_in = 1'b0;
    req_valid_in = '0;
    step();
    chk_out("idle", 1'b0, 16'd0, 2'd0);
    chk("idle_ready", 32'(req_ready_out), 32'h0);

    // single channel 2: 200*150 = 30000
    a_in[2] = 8'd200;
    b_in[2] = 8'd150;
    req_valid_in = 4'b0100;
    #1 chk("single_ready", 32'(req_ready_out), 32'b0100);
    step();
    req_valid_in = '0;
    chk("single_lat1", 32'(res_valid_out), 32'd0);
    step();
    chk_out("single", 1'b1, 16'd30000, 2'd2);
    step();
    chk("single_gone", 32'(res_valid_out), 32'd0);

    // reset mid-flight: pointer is 3 after ch2, so ch3 wins first
    a_in[1] = 8'd5; b_in[1] = 8'd5;
    a_in[3] = 8'd7; b_in[3] = 8'd7;
    req_valid_in = 4'b1010;
    #1 chk("mf_ready3", 32'(req_ready_out), 32'b1000);
    step();
    rst_in = 1'b1;
    #1 chk("mf_rst_ready", 32'(req_ready_out), 32'h0);
    step();
    rst_in = 1'b0;
    req_valid_in = '0;
    chk_out("mf_flush0", 1'b0, 16'd0, 2'd0);
    step();
    chk("mf_flush1", 32'(res_valid_out), 32'd0);
    step();
    chk("mf_flush2", 32'(res_valid_out), 32'd0);

    // rotation from pointer 0: a = ch+1, b = 10
    for (int i = 0; i < 4; i++) begin
      a_in[i] = 8'(i + 1);
      b_in[i] = 8'd10;
    end
    req_valid_in = 4'hF;
    for (int k = 0; k < 10; k++) begin
      #1 chk($sformatf("rot%0d_ready", k), 32'(req_ready_out), 32'(1 << (k % 4)));
      if (k >= 2)
        chk_out($sformatf("rot%0d", k), 1'b1, 16'(10 * ((k - 2) % 4 + 1)), 2'((k - 2) % 4));
      step();
    end

    // backpressure for 3 cycles; output holds the k=8 result (ch0, 10)
    res_ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp%0d_ready", k), 32'(req_ready_out), 32'h0);
      chk_out($sformatf("bp%0d", k), 1'b1, 16'd10, 2'd0);
      step();
    end
    // release: grant resumes in the same cycle at ch2 (last accepted was ch1)
    res_ready_in = 1'b1;
    #1 chk("rel_ready", 32'(req_ready_out), 32'b0100);
    chk_out("rel0", 1'b1, 16'd10, 2'd0);
    step();
    chk_out("rel1", 1'b1, 16'd20, 2'd1);
    step();
    chk_out("rel2", 1'b1, 16'd30, 2'd2);
    step();
    chk_out("rel3", 1'b1, 16'd40, 2'd3);

    // reset asserted while stalled: reset wins
    res_ready_in = 1'b0;
    step();
    rst_in = 1'b1;
    step();
    chk_out("rst_stall", 1'b0, 16'd0, 2'd0);
    chk("rst_stall_ready", 32'(req_ready_out), 32'h0);
    rst_in = 1'b0;
    res_ready_in = 1'b1;
    req_valid_in = '0;
    step();

    // signed vs unsigned on ch0
    a_in[0] = 8'hFF; b_in[0] = 8'h80;
    req_valid_in = 4'b0001;
    #1 chk("sgn_ready", 32'(s_req_ready), 32'b0001);
    step();
    a_in[0] = 8'h7F; b_in[0] = 8'h80;
    step();
    req_valid_in = '0;
    chk_out("uns_v0", 1'b1, 16'h7F80, 2'd0);
    chk("sgn_v0_valid", 32'(s_res_valid), 32'd1);
    chk("sgn_v0_data", 32'(s_res_data), 32'h0080);
    chk("sgn_v0_ch", 32'(s_res_ch), 32'd0);
    step();
    chk_out("uns_v1", 1'b1, 16'h3F80, 2'd0);
    chk("sgn_v1_data", 32'(s_res_data), 32'hC080);
    step();
    chk("sgn_idle", 32'(s_res_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
